me_mv_collector: RTL and testbench
==================================

// Module: me_mv_collector
// PURPOSE
//  Downstream consumer of me_top. Runs NUM_BLOCKS full searches through me_top's
//  4-phase req/ack handshake and captures min_cnt/min_sad after each one.
//  Converts min_cnt into a signed motion vector (mv_x, mv_y) with an iterative
//  divider, then pushes {blk_idx, mv_x, mv_y, sad} into an output FIFO with a
//  valid/ready interface.
// PARAMETERS
//  TB_LENGTH    16  template block edge; must match me_top
//  SW_LENGTH    64  search window edge; must match me_top
//  PE_OUT_WIDTH 8   PE output width; must match me_top
//  NUM_BLOCKS   4   searches per start
//  FIFO_DEPTH   4   output FIFO entries (power of 2, >=2)
//  derived: RANGE=SW-TB+1 (49), OFFSET=(SW-TB)/2 (24), CNT_W=$clog2(RANGE**2) (12),
//           SAD_W=$clog2(TB**2)+PE_OUT_WIDTH (16), MV_W=$clog2(RANGE)+1 (7), BLK_W=$clog2(NUM_BLOCKS)
// PORTS
//  clk        in  1      clock; all logic on posedge
//  rst        in  1      synchronous, active-high reset
//  start      in  1      one-cycle pulse, begins a run; ignored unless IDLE
//  busy       out 1      high from the cycle after accepted start until done
//  done       out 1      one-cycle pulse after the last block is pushed
//  err        out 1      sticky; set if min_cnt >= RANGE*RANGE; cleared by start or rst
//  me_req     out 1      request to me_top
//  me_ack     in  1      acknowledge from me_top
//  me_min_cnt in  CNT_W  me_top min_cnt; valid while me_ack=1
//  me_min_sad in  SAD_W  me_top min_sad; valid while me_ack=1
//  out_valid  out 1      FIFO not empty
//  out_ready  in  1      consumer accepts the head entry when out_valid&&out_ready
//  out_blk    out BLK_W  block index of the head entry
//  out_mv_x   out MV_W   signed horizontal MV, range -OFFSET..+OFFSET
//  out_mv_y   out MV_W   signed vertical MV
//  out_sad    out SAD_W  SAD of the head entry
// BEHAVIOUR
//  Reset: state=IDLE, me_req=0, busy=0, done=0, err=0, FIFO emptied, out_valid=0.
//   Outputs other than these are don't-care while out_valid=0.
//  FSM:
//   IDLE->REQ on start (blk_idx=0, err cleared).
//   REQ: me_req=1; on me_ack=1 latch cnt/sad -> RELEASE.
//   RELEASE: me_req=0; wait for me_ack=0 -> DIV (the 4-phase handshake completes
//    before the next request).
//   DIV: q=0, r=cnt; each cycle if r>=RANGE && q<RANGE-1: r-=RANGE, q++; otherwise -> PUSH.
//    If the loop stops with r>=RANGE: set err, force r=RANGE-1.
//    Takes q+1 cycles; max RANGE cycles.
//   PUSH: mv_x=r-OFFSET, mv_y=q-OFFSET (signed, MV_W). Write the entry when the FIFO
//    is not full, or full with a pop in the same cycle; otherwise stall in PUSH.
//    After the write: if blk_idx==NUM_BLOCKS-1 -> IDLE with done=1 for one cycle;
//    else blk_idx++ and -> REQ.
//  min_cnt encoding: cnt = y_idx*RANGE + x_idx (raster order, top-left = 0).
//  FIFO: first-word fall-through; the head entry is visible on out_* while
//   out_valid=1; simultaneous push and pop allowed in any fill state.
//  me_req is registered; it never rises in the same cycle me_ack=1 is sampled
//   from the previous transaction.
//  start while busy: ignored. rst mid-run: me_req drops the next cycle and the
//   FIFO is flushed. me_top must tolerate me_req falling without an ack.
// TESTING
//  1 cnt=1200, sad=0x0123 with NUM_BLOCKS=1 -> one entry, mv=(0,0), sad=0x0123;
//    done pulses once; busy low after done.
//  2 cnt=0 -> mv=(-24,-24); cnt=2400 -> mv=(+24,+24), DIV lasts 49 cycles;
//    cnt=1224 -> mv=(+24,0).
//  3 cnt=3000 (out of range) -> err=1, entry mv=(+24,+24); the next start clears err.
//  4 out_ready=0, NUM_BLOCKS=6, FIFO_DEPTH=4 -> 4 entries, FSM stalls in PUSH with
//    me_req=0; raise out_ready -> blocks 0..5 drain in order.
//  5 Hold me_ack=1 for 10 cycles after capture -> me_req stays 0, no second capture;
//    next req only after ack falls.
//  6 Assert rst during DIV of block 2 -> next cycle out_valid=0, me_req=0, busy=0;
//    start then restarts at blk 0.

Source files
------------

// File: rtl/me_mv_collector.sv
// me_mv_collector: drives me_top through NUM_BLOCKS searches using a 4-phase
// req/ack handshake. Each captured min_cnt is split into (x, y) by repeated
// subtraction. The resulting signed motion vector and SAD are queued in a
// first-word fall-through output FIFO with a valid/ready interface.
module me_mv_collector #(
    parameter int TB_LENGTH    = 16,
    parameter int SW_LENGTH    = 64,
    parameter int PE_OUT_WIDTH = 8,
    parameter int NUM_BLOCKS   = 4,
    parameter int FIFO_DEPTH   = 4,
    localparam int RANGE = SW_LENGTH - TB_LENGTH + 1,
    localparam int CNT_W = $clog2(RANGE * RANGE),
    localparam int SAD_W = $clog2(TB_LENGTH * TB_LENGTH) + PE_OUT_WIDTH,
    localparam int MV_W  = $clog2(RANGE) + 1,
    localparam int BLK_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             me_req,
    input  logic             me_ack,
    input  logic [CNT_W-1:0] me_min_cnt,
    input  logic [SAD_W-1:0] me_min_sad,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_blk,
    output logic [MV_W-1:0]  out_mv_x,
    output logic [MV_W-1:0]  out_mv_y,
    output logic [SAD_W-1:0] out_sad
);

    localparam int OFFSET  = (SW_LENGTH - TB_LENGTH) / 2;
    localparam int Q_W     = $clog2(RANGE);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = BLK_W + 2 * MV_W + SAD_W;

    localparam logic [CNT_W-1:0] RANGE_C  = CNT_W'(RANGE);
    localparam logic [CNT_W-1:0] R_MAX    = CNT_W'(RANGE - 1);
    localparam logic [Q_W-1:0]   Q_MAX    = Q_W'(RANGE - 1);
    localparam logic [MV_W-1:0]  OFFSET_C = MV_W'(OFFSET);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(NUM_BLOCKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RELEASE,
        S_DIV,
        S_PUSH
    } state_t;

    state_t             state_q, state_d;
    logic [BLK_W-1:0]   blk_q, blk_d;
    logic [CNT_W-1:0]   r_q, r_d;
    logic [Q_W-1:0]     q_q, q_d;
    logic [SAD_W-1:0]   sad_q, sad_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               me_req_q, me_req_d;
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0] mem_d [FIFO_DEPTH];

    logic               div_step;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push;
    logic               pop;
    logic               last_blk;
    logic [MV_W-1:0]    mv_x;
    logic [MV_W-1:0]    mv_y;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head;

    // Divider, FIFO status and the entry about to be written
    always_comb begin
        div_step   = (r_q >= RANGE_C) && (q_q < Q_MAX);
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        pop        = !fifo_empty && out_ready;
        push       = (state_q == S_PUSH) && (!fifo_full || pop);
        last_blk   = (blk_q == BLK_LAST);
        mv_x       = r_q[MV_W-1:0] - OFFSET_C;
        mv_y       = MV_W'(q_q) - OFFSET_C;
        push_entry = {blk_q, mv_x, mv_y, sad_q};
        head       = mem_q[rd_ptr_q[PTR_W-1:0]];
    end

    // State register and all datapath/FIFO control flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            blk_q    <= '0;
            r_q      <= '0;
            q_q      <= '0;
            sad_q    <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            me_req_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            blk_q    <= blk_d;
            r_q      <= r_d;
            q_q      <= q_d;
            sad_q    <= sad_d;
            err_q    <= err_d;
            done_q   <= done_d;
            me_req_q <= me_req_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage; contents are meaningless while empty, so no reset is needed
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Next-state logic: the handshake must fully close (ack low) before dividing
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start)    state_d = S_REQ;
            S_REQ:     if (me_ack)   state_d = S_RELEASE;
            S_RELEASE: if (!me_ack)  state_d = S_DIV;
            S_DIV:     if (!div_step) state_d = S_PUSH;
            S_PUSH:    if (push)     state_d = last_blk ? S_IDLE : S_REQ;
            default:                 state_d = S_IDLE;
        endcase
    end

    // FSM outputs: registered request and the one-cycle completion pulse
    always_comb begin
        me_req_d = (state_d == S_REQ);
        done_d   = (state_q == S_PUSH) && push && last_blk;
    end

    // Datapath: capture, repeated-subtraction divide, block counter, error flag
    always_comb begin
        blk_d = blk_q;
        r_d   = r_q;
        q_d   = q_q;
        sad_d = sad_q;
        err_d = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    blk_d = '0;
                    err_d = 1'b0;
                end
            end
            S_REQ: begin
                if (me_ack) begin
                    r_d   = me_min_cnt;
                    q_d   = '0;
                    sad_d = me_min_sad;
                end
            end
            S_DIV: begin
                if (div_step) begin
                    r_d = r_q - RANGE_C;
                    q_d = q_q + Q_W'(1);
                end else if (r_q >= RANGE_C) begin
                    err_d = 1'b1;
                    r_d   = R_MAX;
                end
            end
            S_PUSH: begin
                if (push && !last_blk) begin
                    blk_d = blk_q + BLK_W'(1);
                end
            end
            default: ;
        endcase
    end

    // FIFO pointer and storage updates; push and pop may coincide in any fill state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = push_entry;
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign me_req    = me_req_q;
    assign out_valid = !fifo_empty;
    assign out_blk   = head[ENTRY_W-1 -: BLK_W];
    assign out_mv_x  = head[SAD_W+MV_W +: MV_W];
    assign out_mv_y  = head[SAD_W +: MV_W];
    assign out_sad   = head[SAD_W-1:0];

endmodule

// File: tb/tb_me_mv_collector.sv
// Bench for me_mv_collector: plays the role of me_top on the req/ack side,
// consumes the output FIFO with configurable backpressure and compares every
// popped entry against a model that splits min_cnt with plain division.
module tb_me_mv_collector;

    localparam int NUM_BLOCKS = 6;
    localparam int RANGE      = 49;
    localparam int OFFSET     = 24;
    localparam int CNT_W      = 12;
    localparam int SAD_W      = 16;
    localparam int MV_W       = 7;
    localparam int BLK_W      = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             busy;
    logic             done;
    logic             err;
    logic             me_req;
    logic             me_ack;
    logic [CNT_W-1:0] me_min_cnt;
    logic [SAD_W-1:0] me_min_sad;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [BLK_W-1:0] out_blk;
    logic [MV_W-1:0]  out_mv_x;
    logic [MV_W-1:0]  out_mv_y;
    logic [SAD_W-1:0] out_sad;

    typedef struct {
        int blk;
        int mx;
        int my;
        int sad;
    } entry_t;

    entry_t sb[$];
    entry_t consExp;
    int     checks     = 0;
    int     passes     = 0;
    int     doneTotal  = 0;
    int     readyMode  = 1;
    int     cntTab[NUM_BLOCKS];
    int     sadTab[NUM_BLOCKS];
    int     holdTab[NUM_BLOCKS];

    me_mv_collector #(
        .TB_LENGTH(16),
        .SW_LENGTH(64),
        .PE_OUT_WIDTH(8),
        .NUM_BLOCKS(NUM_BLOCKS),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .busy(busy),
        .done(done),
        .err(err),
        .me_req(me_req),
        .me_ack(me_ack),
        .me_min_cnt(me_min_cnt),
        .me_min_sad(me_min_sad),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_blk(out_blk),
        .out_mv_x(out_mv_x),
        .out_mv_y(out_mv_y),
        .out_sad(out_sad)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Every comparison funnels through here so the counts stay honest
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    endtask

    // All stimulus and sampling happens on the falling edge, well away from posedge
    task automatic tick();
        @(negedge clk);
    endtask

    // Expected vector: raster index -> (x, y), out-of-range counts pin to the far corner
    function automatic entry_t refEntry(input int blk, input int cnt, input int sad);
        entry_t e;
        int x;
        int y;
        if (cnt >= RANGE * RANGE) begin
            x = RANGE - 1;
            y = RANGE - 1;
        end else begin
            x = cnt % RANGE;
            y = cnt / RANGE;
        end
        e.blk = blk;
        e.mx  = x - OFFSET;
        e.my  = y - OFFSET;
        e.sad = sad;
        return e;
    endfunction

    // Row index the divider must arrive at, which sets how long it runs
    function automatic int refRow(input int cnt);
        return (cnt >= RANGE * RANGE) ? RANGE - 1 : cnt / RANGE;
    endfunction

    // Count done pulses so runs can confirm exactly one per start
    always @(negedge clk) begin
        if (done) doneTotal++;
    end

    // Output consumer: picks a ready value, and whatever it accepts must match the model
    always @(negedge clk) begin
        int mx;
        int my;
        if (rst) begin
            out_ready = 1'b0;
        end else begin
            case (readyMode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_entry", 1, 0);
                end else begin
                    consExp = sb.pop_front();
                    mx = $signed(out_mv_x);
                    my = $signed(out_mv_y);
                    checkOutput("out_blk", int'(out_blk), consExp.blk);
                    checkOutput("out_mv_x", mx, consExp.mx);
                    checkOutput("out_mv_y", my, consExp.my);
                    checkOutput("out_sad", int'(out_sad), consExp.sad);
                end
            end
        end
    end

    // Act as me_top for one block: wait for req, ack with data, hold ack, release.
    // With checkLat the bench also times the divide via the next req/done.
    task automatic applyStimulus(input int blk, input int cnt, input int sad, input int hold,
                                 input bit checkLat, input bit extraStart);
        int  n;
        int  delay;
        bit  seen;
        seen = 1'b0;
        for (n = 0; n < 300; n++) begin
            if (me_req) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) begin
            checkOutput("req_timeout", 0, 1);
            return;
        end
        checkOutput("busy_in_req", int'(busy), 1);
        delay = extraStart ? 2 : $urandom_range(0, 3);
        for (int i = 0; i < delay; i++) begin
            start = extraStart && (i == 0);
            tick();
            start = 1'b0;
        end
        checkOutput("req_held", int'(me_req), 1);
        me_ack     = 1'b1;
        me_min_cnt = CNT_W'(cnt);
        me_min_sad = SAD_W'(sad);
        sb.push_back(refEntry(blk, cnt, sad));
        tick();
        checkOutput("req_drop_after_ack", int'(me_req), 0);
        me_min_cnt = CNT_W'($urandom_range(0, 4095));
        me_min_sad = SAD_W'($urandom_range(0, 65535));
        for (int i = 0; i < hold; i++) tick();
        if (hold > 0) checkOutput("req_low_while_ack", int'(me_req), 0);
        me_ack = 1'b0;
        if (checkLat) begin
            n    = 0;
            seen = 1'b0;
            while (n < 300 && !seen) begin
                tick();
                n++;
                if (me_req || done) seen = 1'b1;
            end
            checkOutput("div_latency", n, refRow(cnt) + 3);
        end
    endtask

    // One full run of NUM_BLOCKS blocks using cntTab/sadTab/holdTab
    task automatic runBlocks(input int mode, input bit checkLat, input bit expErr, input bit stallTest);
        int doneBefore;
        int n;
        doneBefore = doneTotal;
        readyMode  = stallTest ? 0 : mode;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("busy_after_start", int'(busy), 1);
        checkOutput("err_cleared_on_start", int'(err), 0);
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            applyStimulus(b, cntTab[b], sadTab[b], holdTab[b],
                          checkLat && !stallTest, (b == 2) && !stallTest);
            if (stallTest && b == 4) begin
                for (int i = 0; i < 80; i++) tick();
                checkOutput("stall_req_low", int'(me_req), 0);
                checkOutput("stall_busy", int'(busy), 1);
                checkOutput("stall_valid", int'(out_valid), 1);
                checkOutput("stall_sb_depth", sb.size(), 5);
                readyMode = 1;
            end
        end
        n = 0;
        while (doneTotal == doneBefore && n < 400) begin
            tick();
            n++;
        end
        for (int i = 0; i < 3; i++) tick();
        checkOutput("done_once", doneTotal - doneBefore, 1);
        checkOutput("busy_after_done", int'(busy), 0);
        checkOutput("err_flag", int'(err), int'(expErr));
        readyMode = 1;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            tick();
            n++;
        end
        checkOutput("sb_drained", sb.size(), 0);
        checkOutput("fifo_empty", int'(out_valid), 0);
    endtask

    // Randomised table; occasionally an out-of-range count to exercise err
    task automatic fillRandom(output bit expErr, input bit allowBad);
        expErr = 1'b0;
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            if (allowBad && $urandom_range(0, 7) == 0) cntTab[b] = $urandom_range(2401, 4095);
            else                                      cntTab[b] = $urandom_range(0, 2400);
            if (cntTab[b] >= RANGE * RANGE) expErr = 1'b1;
            sadTab[b]  = $urandom_range(0, 65535);
            holdTab[b] = $urandom_range(0, 4);
        end
    endtask

    // Hang guard
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence
    initial begin
        bit expErr;
        rst        = 1'b1;
        start      = 1'b0;
        me_ack     = 1'b0;
        me_min_cnt = '0;
        me_min_sad = '0;
        for (int i = 0; i < 3; i++) tick();
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_err", int'(err), 0);
        checkOutput("rst_me_req", int'(me_req), 0);
        rst = 1'b0;
        tick();

        // Directed corners: centre, top-left, bottom-right (longest divide), right edge
        cntTab  = '{1200, 0, 2400, 1224, 49, 48};
        sadTab  = '{16'h0123, 16'hffff, 0, 16'h8001, 7, 16'h4242};
        holdTab = '{0, 10, 2, 0, 1, 3};
        runBlocks(1, 1'b1, 1'b0, 1'b0);

        // Out-of-range counts under random backpressure; err must stick until next start
        fillRandom(expErr, 1'b0);
        cntTab[1] = 3000;
        cntTab[4] = 4095;
        runBlocks(2, 1'b0, 1'b1, 1'b0);

        // Consumer stalled: FIFO fills, collector waits in PUSH, then drains in order
        fillRandom(expErr, 1'b0);
        runBlocks(0, 1'b0, expErr, 1'b1);

        // Reset in the middle of block 2's divide
        readyMode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        applyStimulus(0, $urandom_range(0, 2400), $urandom_range(0, 65535), 0, 1'b1, 1'b0);
        applyStimulus(1, $urandom_range(0, 2400), $urandom_range(0, 65535), 1, 1'b1, 1'b0);
        applyStimulus(2, 2400, 16'h5555, 0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        checkOutput("midrst_out_valid", int'(out_valid), 0);
        checkOutput("midrst_me_req", int'(me_req), 0);
        checkOutput("midrst_busy", int'(busy), 0);
        rst = 1'b0;
        sb.delete();
        tick();

        // Restart after reset must begin at block 0
        fillRandom(expErr, 1'b0);
        runBlocks(1, 1'b1, 1'b0, 1'b0);

        // A few fully random runs
        for (int r = 0; r < 4; r++) begin
            fillRandom(expErr, 1'b1);
            runBlocks(2, 1'b0, expErr, 1'b0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
